// File: rtl/optic_pkg.sv
// Shared encodings and default thresholds for the optic link supervisor.
package optic_pkg;

  typedef enum logic [1:0] {
    LS_DOWN  = 2'b00,
    LS_TRAIN = 2'b01,
    LS_UP    = 2'b10,
    LS_FAULT = 2'b11
  } link_state_e;

  typedef enum logic [1:0] {
    FM_NONE       = 2'b00,
    FM_TX_COMM    = 2'b01,
    FM_TX_CRC     = 2'b10,
    FM_FORCE_LINK = 2'b11
  } fault_mode_e;

  localparam int DEF_CH_NUM   = 14;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_UP_THR   = 4;
  localparam int DEF_DOWN_THR = 3;

endpackage

// File: rtl/optic_link_fsm.sv
// Per-channel link FSM: window accumulation, good/bad run counters, error counters.
// OPTIC_SUP_TIMEOUT_EN: a window without any rx frame is bad and raises o_frame_timeout.
module optic_link_fsm
  import optic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int UP_THR   = DEF_UP_THR,
  parameter int DOWN_THR = DEF_DOWN_THR
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_win_end,
  input  logic             i_frame_ok,
  input  logic             i_comm_err,
  input  logic             i_verify_err,
  input  logic [1:0]       i_fault_mode,
  input  logic             i_cnt_clr,
  output logic             o_tx_comm_fault,
  output logic             o_tx_crc_fault,
  output logic [1:0]       o_link_state,
  output logic             o_link_up,
  output logic [CNT_W-1:0] o_comm_err_cnt,
  output logic [CNT_W-1:0] o_verify_err_cnt,
  output logic             o_frame_timeout
);

  localparam int GW = $clog2(UP_THR + 1);
  localparam int DW = $clog2(DOWN_THR + 1);
  localparam logic [GW-1:0] GMAX = GW'(UP_THR);
  localparam logic [DW-1:0] DMAX = DW'(DOWN_THR);

  link_state_e      r_state;
  logic [GW-1:0]    r_good;
  logic [DW-1:0]    r_bad;
  logic             r_seen_err;
  logic             r_tx_comm;
  logic             r_tx_crc;
  logic [CNT_W-1:0] r_comm_cnt;
  logic [CNT_W-1:0] r_verify_cnt;
  logic             w_good;
  logic [GW-1:0]    w_good_nxt;
  logic [DW-1:0]    w_bad_nxt;

  always_comb begin
    w_good_nxt = (r_good == GMAX) ? r_good : r_good + 1'b1;
    w_bad_nxt  = (r_bad == DMAX) ? r_bad : r_bad + 1'b1;
  end

  // Events coincident with the window end seed the new window, not the old one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_seen_err <= 1'b0;
    else if (i_win_end) r_seen_err <= i_comm_err | i_verify_err;
    else                r_seen_err <= r_seen_err | i_comm_err | i_verify_err;
  end

`ifdef OPTIC_SUP_TIMEOUT_EN
  logic r_seen_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_seen_ok <= 1'b0;
    else if (i_win_end) r_seen_ok <= i_frame_ok;
    else                r_seen_ok <= r_seen_ok | i_frame_ok;
  end

  assign w_good          = r_seen_ok & ~r_seen_err;
  assign o_frame_timeout = i_win_end & ~r_seen_ok;
`else
  assign w_good          = ~r_seen_err;
  assign o_frame_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LS_DOWN;
      r_good  <= '0;
      r_bad   <= '0;
    end else if (i_fault_mode == FM_FORCE_LINK) begin
      r_state <= LS_FAULT;
      r_good  <= '0;
      r_bad   <= '0;
    end else begin
      case (r_state)
        LS_DOWN: begin
          if (i_frame_ok) begin
            r_state <= LS_TRAIN;
            r_good  <= '0;
          end
        end
        LS_TRAIN: begin
          if (i_win_end) begin
            if (w_good) begin
              r_good <= w_good_nxt;
              if (w_good_nxt == GMAX) begin
                r_state <= LS_UP;
                r_bad   <= '0;
              end
            end else begin
              r_state <= LS_DOWN;
              r_good  <= '0;
            end
          end
        end
        LS_UP: begin
          if (i_win_end) begin
            if (w_good) begin
              r_bad <= '0;
            end else if (w_bad_nxt == DMAX) begin
              r_state <= LS_DOWN;
              r_good  <= '0;
              r_bad   <= '0;
            end else begin
              r_bad <= w_bad_nxt;
            end
          end
        end
        default: begin
          r_state <= LS_DOWN;
          r_good  <= '0;
          r_bad   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_comm <= 1'b0;
      r_tx_crc  <= 1'b0;
    end else if (i_win_end) begin
      r_tx_comm <= (i_fault_mode == FM_TX_COMM);
      r_tx_crc  <= (i_fault_mode == FM_TX_CRC);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_comm_cnt   <= '0;
      r_verify_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_comm_cnt   <= '0;
      r_verify_cnt <= '0;
    end else begin
      if (i_comm_err && (r_comm_cnt != '1))     r_comm_cnt   <= r_comm_cnt + 1'b1;
      if (i_verify_err && (r_verify_cnt != '1)) r_verify_cnt <= r_verify_cnt + 1'b1;
    end
  end

  assign o_link_state     = r_state;
  assign o_link_up        = (r_state == LS_UP);
  assign o_tx_comm_fault  = r_tx_comm;
  assign o_tx_crc_fault   = r_tx_crc;
  assign o_comm_err_cnt   = r_comm_cnt;
  assign o_verify_err_cnt = r_verify_cnt;

endmodule

// File: rtl/optic_link_supervisor.sv
// Optic link supervisor: frame-boundary window generator plus CH_NUM per-channel link FSMs.
// OPTIC_SUP_TIMEOUT_EN enables per-window missing-frame detection (frame_timeout).
module optic_link_supervisor
  import optic_pkg::*;
#(
  parameter int CH_NUM   = DEF_CH_NUM,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int UP_THR   = DEF_UP_THR,
  parameter int DOWN_THR = DEF_DOWN_THR
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    sfp_rx_end_extend,
  input  logic [CH_NUM-1:0]       rx_frame_ok,
  input  logic [CH_NUM-1:0]       rx_comm_err,
  input  logic [CH_NUM-1:0]       rx_verify_err,
  input  logic [CH_NUM*2-1:0]     fault_mode,
  input  logic                    cnt_clr,
  output logic                    trans_start,
  output logic [CH_NUM-1:0]       tx_comm_fault,
  output logic [CH_NUM-1:0]       tx_crc_fault,
  output logic [CH_NUM*2-1:0]     link_state,
  output logic [CH_NUM-1:0]       link_up,
  output logic [CH_NUM*CNT_W-1:0] comm_err_cnt,
  output logic [CH_NUM*CNT_W-1:0] verify_err_cnt,
  output logic [CH_NUM-1:0]       frame_timeout
);

  logic r_end_d;
  logic r_trans_start;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_end_d       <= 1'b0;
      r_trans_start <= 1'b0;
    end else begin
      r_end_d       <= sfp_rx_end_extend;
      r_trans_start <= sfp_rx_end_extend & ~r_end_d;
    end
  end

  assign trans_start = r_trans_start;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    optic_link_fsm #(
      .CNT_W    (CNT_W),
      .UP_THR   (UP_THR),
      .DOWN_THR (DOWN_THR)
    ) u_fsm (
      .i_clk            (clk_sys),
      .i_rst_n          (reset_n),
      .i_win_end        (r_trans_start),
      .i_frame_ok       (rx_frame_ok[g]),
      .i_comm_err       (rx_comm_err[g]),
      .i_verify_err     (rx_verify_err[g]),
      .i_fault_mode     (fault_mode[2*g +: 2]),
      .i_cnt_clr        (cnt_clr),
      .o_tx_comm_fault  (tx_comm_fault[g]),
      .o_tx_crc_fault   (tx_crc_fault[g]),
      .o_link_state     (link_state[2*g +: 2]),
      .o_link_up        (link_up[g]),
      .o_comm_err_cnt   (comm_err_cnt[g*CNT_W +: CNT_W]),
      .o_verify_err_cnt (verify_err_cnt[g*CNT_W +: CNT_W]),
      .o_frame_timeout  (frame_timeout[g])
    );
  end

endmodule

// File: doc/optic_link_supervisor.md
OPTIC_LINK_SUPERVISOR -- requirements
Module: optic_link_supervisor

Interface
REQ-001 SHALL have parameter CH_NUM, default 14, number of optic channels supervised.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel error counter.
REQ-003 SHALL have parameter UP_THR, default 4, consecutive good windows needed to declare link up.
REQ-004 SHALL have parameter DOWN_THR, default 3, consecutive bad windows needed to drop an up link.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_sys  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-006 SHALL have port sfp_rx_end_extend  in  1  frame-end level; its rising edge defines a window boundary.
REQ-007 SHALL have ports rx_frame_ok / rx_comm_err / rx_verify_err  in  CH_NUM each  one-cycle per-channel receive event pulses.
REQ-008 SHALL have port fault_mode  in  CH_NUM*2  per channel: 00 none, 01 tx comm fault, 10 tx crc fault, 11 force link fault.
REQ-009 SHALL have port cnt_clr  in  1  synchronous clear of all error counters.
REQ-010 SHALL have outputs trans_start  out  1  tx frame start pulse; tx_comm_fault, tx_crc_fault  out  CH_NUM  per-channel tx fault controls.
REQ-011 SHALL have outputs link_state  out  CH_NUM*2  (00 DOWN, 01 TRAIN, 10 UP, 11 FAULT); link_up  out  CH_NUM  (state==UP).
REQ-012 SHALL have outputs comm_err_cnt, verify_err_cnt  out  CH_NUM*CNT_W  (channel i at [i*CNT_W+:CNT_W]); frame_timeout  out  CH_NUM  one-cycle miss pulse.

Function
REQ-013 trans_start SHALL pulse high exactly one cycle, registered, in the cycle after sfp_rx_end_extend is first sampled high after being sampled low.
REQ-014 Window = cycles between consecutive trans_start pulses; per channel, window is good if >=1 rx_frame_ok and no rx_comm_err/rx_verify_err, else bad.
REQ-015 Window verdict SHALL be evaluated on trans_start; window accumulators clear that same cycle; an event coincident with trans_start belongs to the new window.
REQ-016 FSM per channel: DOWN->TRAIN on any rx_frame_ok; TRAIN->UP when good run reaches UP_THR; TRAIN->DOWN on a bad window.
REQ-017 UP->DOWN when consecutive bad windows reach DOWN_THR; a good window resets the bad run to 0.
REQ-018 Any state->FAULT when fault_mode==11 (highest priority); FAULT->DOWN on the first cycle fault_mode!=11.
REQ-019 tx_comm_fault/tx_crc_fault SHALL reload from fault_mode bits 0/1 only on trans_start, so faults change at frame boundaries; mode 11 sets neither.
REQ-020 Each error pulse SHALL increment its counter by 1, saturating at 2^CNT_W-1; comm and verify error in same cycle increment both.
REQ-021 cnt_clr SHALL take priority over a coincident increment (counter = 0 next cycle).
REQ-022 Good/bad run counters SHALL saturate at their thresholds, never wrap.

Reset
REQ-023 On reset_n low all outputs SHALL be 0: link_state DOWN, counters 0, trans_start 0, tx faults 0, frame_timeout 0; edge detector history 0.
REQ-024 Reset mid-window SHALL discard accumulated window state; first window after release ends at the first trans_start.

Configuration
REQ-025 With OPTIC_SUP_TIMEOUT_EN defined, a window with no rx_frame_ok SHALL be bad and pulse frame_timeout for that channel on the trans_start cycle.
REQ-026 Without OPTIC_SUP_TIMEOUT_EN, missing frames SHALL not make a window bad (only error pulses do) and frame_timeout SHALL be tied 0.

Structure
REQ-027 Package optic_pkg SHALL hold link-state encodings, fault_mode codes and default threshold constants.
REQ-028 Per-channel FSM, run counters and error counters SHALL be sub-module optic_link_fsm, instantiated CH_NUM times by generate.

Verification
REQ-029 Reset then edge on sfp_rx_end_extend -> trans_start exactly one cycle, 1 cycle after sampled rise; held-high level -> no second pulse.
REQ-030 Ch0: rx_frame_ok each window for 5 windows -> DOWN, TRAIN, UP after 4th good window verdict; link_up[0]=1.
REQ-031 Ch0 UP, 3 windows with rx_verify_err -> DOWN after 3rd; verify_err_cnt[0]=3; 2 bad + 1 good + 2 bad -> stays UP.
REQ-032 fault_mode[1:0]=10 mid-window -> tx_crc_fault[0] rises only at next trans_start; fault_mode=11 -> FAULT next cycle, DOWN after clear.
REQ-033 CNT_W=4, 20 rx_comm_err pulses -> comm_err_cnt=15; cnt_clr with coincident pulse -> 0.
REQ-034 With OPTIC_SUP_TIMEOUT_EN, ch2 silent for a window -> frame_timeout[2] pulse on trans_start; without it -> 0, state unchanged.
